// File: rtl/bcd_convert_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Optional macro BCD_SEG_EN adds registered active-low 7-segment outputs HEX0/HEX1.
module bcd_convert_seq #(
    parameter int IN_W   = 5,
    parameter int DIGITS = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [IN_W-1:0]       bin_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  out_valid
`ifdef BCD_SEG_EN
    ,
    output logic [6:0]            HEX0,
    output logic [6:0]            HEX1
`endif
);

    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n + 1) w = i + 1;
        end
        return w;
    endfunction

    localparam int CNT_W = cnt_width(IN_W);
    localparam int BCD_W = 4 * DIGITS;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    shift_q, shift_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   scratch_adj;
    logic               last_iter;

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE);
    assign bcd_out   = bcd_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        count_d     = count_q;
        bcd_d       = bcd_q;
        last_iter   = 1'b0;
        scratch_adj = add3(scratch_q);
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d   = CONV;
                    shift_d   = bin_in;
                    scratch_d = '0;
                    count_d   = CNT_W'(IN_W);
                end
            end
            CONV: begin
                scratch_d = {scratch_adj[BCD_W-2:0], shift_q[IN_W-1]};
                shift_d   = shift_q << 1;
                if (count_q != '0) count_d = count_q - CNT_W'(1);
                // A count of 0 can only follow a corrupted state; leave CONV rather than wrap.
                if (count_q <= CNT_W'(1)) begin
                    last_iter = 1'b1;
                    state_d   = DONE;
                    bcd_d     = scratch_d;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            bcd_q     <= bcd_d;
        end
    end

`ifdef BCD_SEG_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [6:0] hex0_q, hex1_q;

    // Segments follow bcd_out on the same edge; a zero tens digit is blanked.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hex0_q <= 7'b1000000;
            hex1_q <= 7'h7F;
        end else if (last_iter) begin
            hex0_q <= seg7(bcd_d[3:0]);
            hex1_q <= (bcd_d[7:4] == 4'd0) ? 7'h7F : seg7(bcd_d[7:4]);
        end
    end

    assign HEX0 = hex0_q;
    assign HEX1 = hex1_q;
`endif

endmodule
